// File: rtl/msub_sequencer_pkg.sv
// Package for the multi-precision subtraction sequencer: default
// geometry, the state type and the word-counter sizing helper.
package msub_sequencer_pkg;

  localparam int MSUB_WIDTH_DEFAULT   = 4;
  localparam int MSUB_N_WORDS_DEFAULT = 4;

  typedef logic [0:0] msub_state_t;

  // Counter width that can hold 0..n_words-1; never narrower than one bit.
  function automatic int cnt_bits(input int n_words);
    return (n_words > 2) ? $clog2(n_words) : 1;
  endfunction

endpackage

// File: rtl/msub_defs.vh
// Shared definitions for the multi-precision subtraction sequencer:
// FSM state encodings and the total operand width derivation.
// Included by the RTL and by the testbench.
`ifndef MSUB_DEFS_VH
`define MSUB_DEFS_VH

`define MSUB_STATE_IDLE 1'b0
`define MSUB_STATE_RUN  1'b1

// Full operand width from word width and word count.
`define MSUB_TOTAL(w, n) ((w) * (n))

`endif

// File: rtl/subtractor.sv
// Single-word unsigned subtractor with borrow-in and borrow-out.
// Purely combinational: {o_borr, o_sub} = i_a - i_b - i_borr.
module subtractor #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_borr,
  output logic [WIDTH-1:0] o_sub,
  output logic             o_borr
);

  logic [WIDTH:0] full;

  // One extra bit catches the wrap below zero, which is the borrow-out.
  assign full   = {1'b0, i_a} - {1'b0, i_b} - {{WIDTH{1'b0}}, i_borr};
  assign o_sub  = full[WIDTH-1:0];
  assign o_borr = full[WIDTH];

endmodule

// File: rtl/msub_sequencer.sv
// Multi-precision subtraction sequencer.
// Computes a TOTAL-bit a - b - borrow_in by pushing one WIDTH-bit word per
// cycle (least significant first) through a single shared subtractor and
// carrying the borrow between words in a register.
// Optional feature: define MSUB_ZERO_FLAG_EN to add the o_zero port, a
// registered flag that is 1 when the stored difference is all-zero.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for i_start; o_ready=1, last result held on outputs
// RUN   | one word per cycle through the subtractor, cnt = word index
`include "msub_defs.vh"

module msub_sequencer
  import msub_sequencer_pkg::*;
#(
  parameter int WIDTH   = MSUB_WIDTH_DEFAULT,
  parameter int N_WORDS = MSUB_N_WORDS_DEFAULT
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic                                  i_start,
  input  logic [`MSUB_TOTAL(WIDTH, N_WORDS)-1:0] i_a,
  input  logic [`MSUB_TOTAL(WIDTH, N_WORDS)-1:0] i_b,
  input  logic                                  i_borr,
  output logic                                  o_ready,
  output logic                                  o_busy,
  output logic                                  o_done,
  output logic [`MSUB_TOTAL(WIDTH, N_WORDS)-1:0] o_sub,
  output logic                                  o_borr
`ifdef MSUB_ZERO_FLAG_EN
  ,
  output logic                                  o_zero
`endif
);

  localparam int TOTAL = `MSUB_TOTAL(WIDTH, N_WORDS);
  localparam int CW    = cnt_bits(N_WORDS);

  localparam logic [0:0]    IDLE     = `MSUB_STATE_IDLE;
  localparam logic [0:0]    RUN      = `MSUB_STATE_RUN;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_WORDS - 1);

  msub_state_t             state;
  logic [CW-1:0]           cnt;
  logic [TOTAL-1:0]        a_sh;
  logic [TOTAL-1:0]        b_sh;
  logic                    borr_q;
  // Holds only the words already finished; the word in flight joins it
  // in res_next, so the last word lands straight in o_sub.
  logic [TOTAL-WIDTH-1:0]  res_sh;
  logic [TOTAL-1:0]        res_next;

  logic [WIDTH-1:0]        word_diff;
  logic                    word_borr;
  logic                    accept;
  logic                    last_word;

  subtractor #(
    .WIDTH (WIDTH)
  ) u_subtractor (
    .i_a    (a_sh[WIDTH-1:0]),
    .i_b    (b_sh[WIDTH-1:0]),
    .i_borr (borr_q),
    .o_sub  (word_diff),
    .o_borr (word_borr)
  );

  assign accept    = (state == IDLE) && i_start;
  assign last_word = (state == RUN) && (cnt == CNT_LAST);
  assign res_next  = {word_diff, res_sh};

  assign o_ready = (state == IDLE);
  assign o_busy  = (state == RUN);

  // FSM and word counter; the counter stops at the last word index.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            state <= RUN;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (cnt == CNT_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Operand shift registers, running borrow and partial-result collection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      borr_q <= 1'b0;
      res_sh <= '0;
    end else if (accept) begin
      a_sh   <= i_a;
      b_sh   <= i_b;
      borr_q <= i_borr;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> WIDTH;
      b_sh   <= b_sh >> WIDTH;
      borr_q <= word_borr;
      res_sh <= res_next[TOTAL-1:WIDTH];
    end
  end

  // Result registers: updated only on the last word, held otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_done <= 1'b0;
      o_sub  <= '0;
      o_borr <= 1'b0;
`ifdef MSUB_ZERO_FLAG_EN
      o_zero <= 1'b0;
`endif
    end else begin
      o_done <= last_word;
      if (last_word) begin
        o_sub  <= res_next;
        o_borr <= word_borr;
`ifdef MSUB_ZERO_FLAG_EN
        o_zero <= (res_next == '0);
`endif
      end
    end
  end

endmodule
